// File: rtl/mppt_pkg.sv
// Shared MPPT definitions: FSM and comparison-class encodings, default widths, enable-bus bit map.
// No logic; latency n/a.
// No flow control; consumers decode the strobes themselves.
package mppt_pkg;

    localparam int PW_DEF = 12;
    localparam int DW_DEF = 8;

    // Sequencer enable bus bit positions.
    localparam int EN_POT  = 1;
    localparam int EN_DUTY = 2;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COMPARE = 2'd1;
    localparam logic [1:0] ST_UPDATE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        COMPARE = ST_COMPARE,
        UPDATE  = ST_UPDATE
    } state_t;

    typedef enum logic [1:0] {
        FLAT = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } cmp_t;

    function automatic logic cmp_moves(input cmp_t c);
        return (c != FLAT);
    endfunction

endpackage

// File: rtl/duty_step_clamp.sv
// Saturating duty step: add/subtract STEP in DW+1 bits and clamp to [DUTY_MIN, DUTY_MAX].
// Purely combinational, zero latency.
// No flow control; step_en=0 passes duty through untouched.
module duty_step_clamp #(
    parameter int DW       = 8,
    parameter int DUTY_MIN = 13,
    parameter int DUTY_MAX = 242,
    parameter int STEP     = 4
) (
    input  logic [DW-1:0] duty,
    input  logic          dir,
    input  logic          step_en,
    output logic [DW-1:0] duty_next,
    output logic          clamp_hit
);

    localparam logic [DW:0]   MIN_X  = DUTY_MIN[DW:0];
    localparam logic [DW:0]   MAX_X  = DUTY_MAX[DW:0];
    localparam logic [DW:0]   STEP_X = STEP[DW:0];
    localparam logic [DW-1:0] STEP_N = STEP[DW-1:0];

    logic [DW:0] duty_x;
    logic [DW:0] sum_x;
    logic [DW:0] lo_lim_x;

    always_comb begin
        duty_x    = {1'b0, duty};
        sum_x     = duty_x + STEP_X;
        lo_lim_x  = MIN_X + STEP_X;
        duty_next = duty;
        clamp_hit = 1'b0;
        if (step_en) begin
            if (dir) begin
                if (sum_x > MAX_X) begin
                    duty_next = MAX_X[DW-1:0];
                    clamp_hit = 1'b1;
                end else begin
                    duty_next = sum_x[DW-1:0];
                end
            end else begin
                // Testing against MIN+STEP first keeps the subtraction from wrapping.
                if (duty_x < lo_lim_x) begin
                    duty_next = MIN_X[DW-1:0];
                    clamp_hit = 1'b1;
                end else begin
                    duty_next = duty - STEP_N;
                end
            end
        end
    end

endmodule

// File: rtl/po_duty_ctrl.sv
// Perturb-and-observe decision: snapshot power pair on en[2], classify, step/clamp duty.
// Latency: duty/done update 2 edges after the capturing edge; one iteration per 3 cycles.
// No backpressure: en[2] seen while busy is dropped, never queued.
module po_duty_ctrl
    import mppt_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int PW        = PW_DEF,
    parameter int DUTY_INIT = 128,
    parameter int DUTY_MIN  = 13,
    parameter int DUTY_MAX  = 242,
    parameter int STEP      = 4,
    parameter int DEADBAND  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PW-1:0] pot_act,
    input  logic [PW-1:0] pot_ant,
    input  logic [3:0]    en,
    output logic [DW-1:0] duty,
    output logic          dir,
    output logic          busy,
    output logic          done
);

    localparam logic [PW:0] DB_X = DEADBAND[PW:0];

    state_t        state;
    cmp_t          cls;
    cmp_t          cls_next;
    logic [PW-1:0] snap_act;
    logic [PW-1:0] snap_ant;
    logic [PW:0]   act_x;
    logic [PW:0]   ant_x;
    logic          dir_dec;
    logic          step_en;
    logic [DW-1:0] duty_next;
    logic          clamp_hit;

    // Remaining enable bits belong to other pipeline stages.
    logic unused_en;
    assign unused_en = ^{en[3], en[1:0]};

    assign act_x = {1'b0, snap_act};
    assign ant_x = {1'b0, snap_ant};

    always_comb begin
        cls_next = FLAT;
        if (act_x > ant_x + DB_X) begin
            cls_next = UP;
        end else if (act_x + DB_X < ant_x) begin
            cls_next = DOWN;
        end
    end

    assign dir_dec = (cls == DOWN) ? ~dir : dir;
    assign step_en = cmp_moves(cls);

    duty_step_clamp #(
        .DW       (DW),
        .DUTY_MIN (DUTY_MIN),
        .DUTY_MAX (DUTY_MAX),
        .STEP     (STEP)
    ) u_step (
        .duty      (duty),
        .dir       (dir_dec),
        .step_en   (step_en),
        .duty_next (duty_next),
        .clamp_hit (clamp_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cls      <= FLAT;
            snap_act <= '0;
            snap_ant <= '0;
            duty     <= DUTY_INIT[DW-1:0];
            dir      <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en[EN_DUTY]) begin
                        snap_act <= pot_act;
                        snap_ant <= pot_ant;
                        busy     <= 1'b1;
                        state    <= COMPARE;
                    end
                end
                COMPARE: begin
                    cls   <= cls_next;
                    state <= UPDATE;
                end
                UPDATE: begin
                    // FLAT yields duty_next == duty and dir_dec == dir, so no gating needed.
                    duty  <= duty_next;
                    dir   <= dir_dec ^ clamp_hit;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_po_duty_ctrl.sv
// Directed bench for po_duty_ctrl: timing, classification, deadband, clamps, held strobe, reset abort.
module tb_po_duty_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] pot_act;
    logic [11:0] pot_ant;
    logic [3:0]  en;
    logic [7:0]  duty;
    logic        dir;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    po_duty_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .pot_act (pot_act),
        .pot_ant (pot_ant),
        .en      (en),
        .duty    (duty),
        .dir     (dir),
        .busy    (busy),
        .done    (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One en[2] pulse; checks busy/done timing and the resulting duty/dir.
    task automatic run_iter(input int act, input int ant, input int exp_duty, input logic exp_dir,
                            input bit zero_after, input string tag);
        @(negedge clk);
        pot_act = 12'(act);
        pot_ant = 12'(ant);
        en      = 4'b0100;
        @(negedge clk);
        en = 4'b0000;
        if (zero_after) begin
            pot_act = 12'd0;
            pot_ant = 12'd0;
        end
        chk({tag, ".busy0"}, 32'(busy), 32'd1);
        chk({tag, ".done0"}, 32'(done), 32'd0);
        @(negedge clk);
        chk({tag, ".busy1"}, 32'(busy), 32'd1);
        chk({tag, ".done1"}, 32'(done), 32'd0);
        @(negedge clk);
        chk({tag, ".done2"}, 32'(done), 32'd1);
        chk({tag, ".busy2"}, 32'(busy), 32'd0);
        chk({tag, ".duty"}, 32'(duty), 32'(exp_duty));
        chk({tag, ".dir"}, 32'(dir), 32'(exp_dir));
        @(negedge clk);
        chk({tag, ".done3"}, 32'(done), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int ndone;
        int pos [3];

        rst     = 1'b1;
        en      = 4'b0000;
        pot_act = 12'd0;
        pot_ant = 12'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst.duty", 32'(duty), 32'd128);
        chk("rst.dir", 32'(dir), 32'd1);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        rst = 1'b0;

        // Zero snapshots after reset classify as FLAT.
        run_iter(0, 0, 128, 1'b1, 1'b0, "flat_zero");

        // Non-strobe enable bits do nothing.
        @(negedge clk);
        pot_act = 12'd1000;
        pot_ant = 12'd900;
        en = 4'b1011;
        repeat (4) begin
            @(negedge clk);
            chk("other_en.busy", 32'(busy), 32'd0);
        end
        en = 4'b0000;
        chk("other_en.duty", 32'(duty), 32'd128);

        run_iter(1000, 900, 132, 1'b1, 1'b0, "up1");
        run_iter(900, 1000, 128, 1'b0, 1'b1, "down_snap");
        run_iter(1001, 1000, 128, 1'b0, 1'b0, "flat_db1");
        run_iter(1000, 1002, 128, 1'b0, 1'b0, "flat_db2");
        run_iter(1003, 1000, 124, 1'b0, 1'b0, "up_db3");
        run_iter(0, 4095, 128, 1'b1, 1'b0, "down_wide");
        run_iter(4095, 4093, 128, 1'b1, 1'b0, "flat_top");

        // en[2] during busy is dropped.
        @(negedge clk);
        pot_act = 12'd1000;
        pot_ant = 12'd900;
        en = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        en = 4'b0000;
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("busy_ignore.ndone", 32'(ndone), 32'd1);
        chk("busy_ignore.duty", 32'(duty), 32'd132);

        // Asynchronous reset with no clock edge.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async.duty", 32'(duty), 32'd128);
        chk("async.dir", 32'(dir), 32'd1);
        chk("async.busy", 32'(busy), 32'd0);
        chk("async.done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Climb to the upper clamp.
        for (int k = 1; k <= 28; k++)
            run_iter(1000, 900, 128 + 4 * k, 1'b1, 1'b0, $sformatf("ramp%0d", k));
        run_iter(1000, 900, 242, 1'b0, 1'b0, "max_clamp");
        run_iter(900, 1000, 242, 1'b0, 1'b0, "max_down_reclamp");
        run_iter(1000, 900, 238, 1'b0, 1'b0, "max_leave");
        run_iter(900, 1000, 242, 1'b1, 1'b0, "max_exact");
        run_iter(1000, 900, 242, 1'b0, 1'b0, "max_clamp2");

        // Descend to the lower clamp.
        do_reset();
        run_iter(900, 1000, 124, 1'b0, 1'b0, "low_start");
        for (int k = 1; k <= 27; k++)
            run_iter(1000, 900, 124 - 4 * k, 1'b0, 1'b0, $sformatf("fall%0d", k));
        run_iter(1000, 900, 13, 1'b1, 1'b0, "min_clamp");
        run_iter(1000, 900, 17, 1'b1, 1'b0, "min_leave");
        run_iter(900, 1000, 13, 1'b0, 1'b0, "min_exact");
        run_iter(1000, 900, 13, 1'b1, 1'b0, "min_clamp2");

        // Held strobe: one iteration every 3 cycles, then reset aborts the 4th.
        do_reset();
        @(negedge clk);
        pot_act = 12'd1000;
        pot_ant = 12'd900;
        en = 4'b0100;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) begin
                if (ndone < 3) begin
                    pos[ndone] = i;
                    chk($sformatf("held.duty%0d", ndone), 32'(duty), 32'(132 + 4 * ndone));
                end
                ndone++;
            end
        end
        en = 4'b0000;
        chk("held.ndone", 32'(ndone), 32'd3);
        chk("held.pos0", 32'(pos[0]), 32'd2);
        chk("held.pos1", 32'(pos[1]), 32'd5);
        chk("held.pos2", 32'(pos[2]), 32'd8);
        chk("held.busy_cmp", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort.duty", 32'(duty), 32'd128);
        chk("abort.busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort.ndone", 32'(ndone), 32'd0);
        chk("abort.duty_after", 32'(duty), 32'd128);
        chk("abort.dir_after", 32'(dir), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
